vec_reg_streamer: RTL and testbench

- Read-side companion to the 4x512-bit vector register file.
- On command, selects one register, latches its 512-bit contents, and streams them as WORD_W-bit words over a valid/ready interface to the memory/store path.
- Raises a one-cycle done pulse after the last word is accepted.

---
 rtl/vec_reg_streamer.sv | 129 ++++++++++++
 tb/tb_vec_reg_streamer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vec_reg_streamer.sv
// Vector register read streamer: snapshots one register-file entry and streams it as WORD_W-bit words.
// Optional VEC_STREAM_MSW_FIRST_EN emits the most-significant word first (default: least-significant first).
module vec_reg_streamer #(
   parameter  int DATA_W = 512,
   parameter  int WORD_W = 32,
   parameter  int ADDR_W = 2,
   localparam int WORDS  = DATA_W / WORD_W,
   localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] reg_sel,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_FIN    = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   rf_addr_r, rf_addr_s;
   logic [DATA_W-1:0]   buffer_r, buffer_s;
   logic [IDX_W-1:0]    idx_r, idx_s;
   logic [IDX_W-1:0]    slice_s;
   logic                out_valid_r, out_valid_s;
   logic                out_last_r, out_last_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;

   // Next-state and next-output logic; flag outputs are precomputed so they leave registers.
   always_comb begin
      state_s   = state_r;
      rf_addr_s = rf_addr_r;
      buffer_s  = buffer_r;
      idx_s     = idx_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s   = ST_LOAD;
               rf_addr_s = reg_sel;
            end else begin
               state_s   = ST_IDLE;
            end
         end
         ST_LOAD: begin
            buffer_s = rf_data;
            idx_s    = '0;
            state_s  = ST_STREAM;
         end
         ST_STREAM: begin
            // out_valid is always high here, so out_ready alone marks a transfer
            if (out_ready) begin
               if (idx_r == LAST_IDX) begin
                  state_s = ST_FIN;
               end else begin
                  idx_s   = idx_r + IDX_W'(1);
               end
            end else begin
               state_s = ST_STREAM;
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      out_valid_s = (state_s == ST_STREAM);
      out_last_s  = (state_s == ST_STREAM) && (idx_s == LAST_IDX);
      busy_s      = (state_s != ST_IDLE);
      done_s      = (state_s == ST_FIN);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         rf_addr_r   <= '0;
         buffer_r    <= '0;
         idx_r       <= '0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         rf_addr_r   <= rf_addr_s;
         buffer_r    <= buffer_s;
         idx_r       <= idx_s;
         out_valid_r <= out_valid_s;
         out_last_r  <= out_last_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   // Map the transfer counter onto the physical word slice.
   always_comb begin
`ifdef VEC_STREAM_MSW_FIRST_EN
      slice_s = LAST_IDX - idx_r;
`else
      slice_s = idx_r;
`endif
   end

   assign rf_addr   = rf_addr_r;
   assign out_valid = out_valid_r;
   assign out_data  = buffer_r[int'(slice_s) * WORD_W +: WORD_W];
   assign out_index = slice_s;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_vec_reg_streamer.sv
// Randomized self-checking bench for vec_reg_streamer against a word-list reference model.
// Define VEC_STREAM_MSW_FIRST_EN for both RTL and bench to check MSW-first ordering.
module tb_vec_reg_streamer;

   localparam int DATA_W = 512;
   localparam int WORD_W = 32;
   localparam int WORDS  = 16;

   logic              clk;
   logic              reset;
   logic              start;
   logic [1:0]        reg_sel;
   logic [1:0]        rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic [3:0]        out_index;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] rf_mem [4];
   int tests_run;
   int tests_failed;

   vec_reg_streamer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .reg_sel   (reg_sel),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   assign rf_data = rf_mem[rf_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // mode: 0 ready always, 1 pattern 1,0,0 repeating, 2 random
   task automatic stream_cmd(input logic [1:0] sel, input int mode, input int abort_after,
                             input bit poke_write, input bit poke_start);
      logic [DATA_W-1:0] snap;
      logic [DATA_W-1:0] saved;
      logic [WORD_W-1:0] exp_words [$];
      int                exp_idx [$];
      int                j;
      int                cyc;
      bit                poked;
      snap  = rf_mem[sel];
      saved = rf_mem[sel];
      exp_words.delete();
      exp_idx.delete();
      for (int n = 0; n < WORDS; n++) begin
`ifdef VEC_STREAM_MSW_FIRST_EN
         exp_idx.push_back(WORDS - 1 - n);
`else
         exp_idx.push_back(n);
`endif
         exp_words.push_back(snap[exp_idx[n]*WORD_W +: WORD_W]);
      end
      check_eq("idle_busy", {63'd0, busy}, 64'd0);
      start   = 1'b1;
      reg_sel = sel;
      @(posedge clk);
      #1;
      start   = 1'b0;
      reg_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
      check_eq("load_valid", {63'd0, out_valid}, 64'd0);
      check_eq("load_busy", {63'd0, busy}, 64'd1);
      check_eq("rf_addr", {62'd0, rf_addr}, {62'd0, sel});
      @(posedge clk);
      #1;
      j     = 0;
      cyc   = 0;
      poked = 1'b0;
      while (j < WORDS && cyc < 200) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke_start && j == 5 && !poked) begin
            start   = 1'b1;
            reg_sel = 2'(sel + 2'd1);
            poked   = 1'b1;
         end else begin
            start   = 1'b0;
         end
         if (poke_write && j == 3) rf_mem[sel] = '1;
         @(negedge clk);
         if (cyc == 0) check_eq("first_valid", {63'd0, out_valid}, 64'd1);
         check_eq("valid", {63'd0, out_valid}, 64'd1);
         check_eq("data", {32'd0, out_data}, {32'd0, exp_words[j]});
         check_eq("index", {60'd0, out_index}, 64'(exp_idx[j]));
         check_eq("last", {63'd0, out_last}, {63'd0, (j == WORDS - 1)});
         check_eq("done_early", {63'd0, done}, 64'd0);
         @(posedge clk);
         if (out_valid && out_ready) j++;
         cyc++;
         #1;
         if (abort_after > 0 && j == abort_after) begin
            reset = 1'b1;
            #1;
            check_eq("abort_valid", {63'd0, out_valid}, 64'd0);
            check_eq("abort_busy", {63'd0, busy}, 64'd0);
            check_eq("abort_rf_addr", {62'd0, rf_addr}, 64'd0);
            @(posedge clk);
            #1;
            reset     = 1'b0;
            start     = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            check_eq("abort_done", {63'd0, done}, 64'd0);
            check_eq("abort_idle", {63'd0, busy}, 64'd0);
            rf_mem[sel] = saved;
            return;
         end
      end
      start = 1'b0;
      check_eq("transfers", 64'(j), 64'(WORDS));
      if (mode == 0) check_eq("no_bubbles", 64'(cyc), 64'(WORDS));
      @(negedge clk);
      check_eq("fin_done", {63'd0, done}, 64'd1);
      check_eq("fin_valid", {63'd0, out_valid}, 64'd0);
      check_eq("fin_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      check_eq("done_once", {63'd0, done}, 64'd0);
      check_eq("idle_after", {63'd0, busy}, 64'd0);
      check_eq("rf_addr_hold", {62'd0, rf_addr}, {62'd0, sel});
      rf_mem[sel] = saved;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset     = 1'b1;
      start     = 1'b0;
      reg_sel   = 2'd0;
      out_ready = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < WORDS; k++) begin
            rf_mem[r][k*WORD_W +: WORD_W] = (r == 2) ? (32'hA000_0000 + 32'(k)) : $urandom;
         end
      end
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_done", {63'd0, done}, 64'd0);
      check_eq("rst_last", {63'd0, out_last}, 64'd0);
      check_eq("rst_rf_addr", {62'd0, rf_addr}, 64'd0);
      check_eq("rst_data", {32'd0, out_data}, 64'd0);
      check_eq("rst_index", {60'd0, out_index}, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      stream_cmd(2'd2, 0, 0, 1'b0, 1'b0);
      check_eq("const_reg2_w0", {32'd0, rf_mem[2][31:0]}, 64'hA000_0000);
      stream_cmd(2'd2, 1, 0, 1'b0, 1'b0);
      stream_cmd(2'd2, 2, 0, 1'b1, 1'b0);
      stream_cmd(2'd2, 0, 0, 1'b0, 1'b1);
      stream_cmd(2'd2, 0, 5, 1'b0, 1'b0);
      stream_cmd(2'd3, 0, 0, 1'b0, 1'b0);
      for (int t = 0; t < 6; t++) begin
         stream_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 2), 0, 1'b0, 1'b0);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
